onchip_mem_crc_checker: RTL and testbench

Read-only scan engine that sits directly upstream of the 204800x32 single-port on-chip RAM and drives its address/chipselect/clken port. On a start pulse it streams a contiguous word range out of the RAM at one word per clock and folds each word into a CRC-32. It reports the final CRC and compares it with an expected value. The fingerprinting subsystem uses it to check code and data regions held in on-chip memory.

---
 rtl/onchip_mem_crc_checker_pkg.sv | 14 +
 rtl/onchip_mem_crc_checker_if.sv | 22 ++
 rtl/onchip_mem_crc_checker_crc32_word_step.sv | 10 +
 rtl/onchip_mem_crc_checker.sv | 89 ++++++++
 tb/tb_onchip_mem_crc_checker.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_mem_crc_checker_pkg.sv
// onchip_mem_crc_checker_pkg: CRC-32 constants, scan FSM states and the word-wide CRC step shared by fingerprint blocks
package onchip_mem_crc_checker_pkg;
  localparam int CRC_W = 32;
  localparam logic [CRC_W-1:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [CRC_W-1:0] CRC_INIT = 32'hFFFFFFFF;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_e;
  // Non-reflected, MSB-first: one word folded per call, fully unrolled.
  function automatic logic [CRC_W-1:0] crc32_step(input logic [CRC_W-1:0] crc, input logic [CRC_W-1:0] data);
    logic [CRC_W-1:0] c;
    c = crc;
    for (int i = CRC_W - 1; i >= 0; i--) c = {c[CRC_W-2:0], 1'b0} ^ ((c[CRC_W-1] ^ data[i]) ? CRC_POLY : '0);
    return c;
  endfunction
endpackage

// File: rtl/onchip_mem_crc_checker_if.sv
// onchip_mem_crc_checker_if: scan control/result signals plus the RAM port; slave = checker side, master = requester/RAM side
interface onchip_mem_crc_checker_if #(parameter int ADDR_W = 18);
  import onchip_mem_crc_checker_pkg::*;
  logic start, abort, busy, done, error, mismatch;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0] word_count;
  logic [CRC_W-1:0] expected_crc, crc_out;
  logic [ADDR_W-1:0] mem_address;
  logic mem_chipselect, mem_write, mem_clken;
  logic [3:0] mem_byteenable;
  logic [CRC_W-1:0] mem_writedata, mem_readdata;
  modport slave (
    input start, abort, base_addr, word_count, expected_crc, mem_readdata,
    output busy, done, error, mismatch, crc_out,
    output mem_address, mem_chipselect, mem_write, mem_clken, mem_byteenable, mem_writedata
  );
  modport master (
    output start, abort, base_addr, word_count, expected_crc, mem_readdata,
    input busy, done, error, mismatch, crc_out,
    input mem_address, mem_chipselect, mem_write, mem_clken, mem_byteenable, mem_writedata
  );
endinterface

// File: rtl/onchip_mem_crc_checker_crc32_word_step.sv
// crc32_word_step: combinational CRC-32 fold of one 32-bit word; crc_i, data_i in, next_crc_o out
module crc32_word_step
  import onchip_mem_crc_checker_pkg::*;
(
  input  logic [CRC_W-1:0] crc_i,
  input  logic [CRC_W-1:0] data_i,
  output logic [CRC_W-1:0] next_crc_o
);
  assign next_crc_o = crc32_step(crc_i, data_i);
endmodule

// File: rtl/onchip_mem_crc_checker.sv
// onchip_mem_crc_checker: streams a RAM word range at 1 word/clk into a CRC-32 and compares it; ports clk, reset, bus (slave: control in, result out, RAM port)
module onchip_mem_crc_checker
  import onchip_mem_crc_checker_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 204800,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic reset,
  onchip_mem_crc_checker_if.slave bus
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0] cnt_q, issue_cnt_q, ret_cnt_q, issue_nxt;
  logic [ADDR_W+1:0] end_addr;
  logic [CRC_W-1:0] exp_q, crc_q, crc_nxt, crc_out_q, fin_crc, fin_exp;
  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] rdata;
  logic error_q, mismatch_q, accept, range_bad, issue, fold, fin_entry, fin_err;
  assign rdata = bus.mem_readdata;
  crc32_word_step u_step (.crc_i(crc_q), .data_i(rdata), .next_crc_o(crc_nxt));
  always_comb begin
    accept = state_q == IDLE && bus.start;
    end_addr = {2'b0, bus.base_addr} + {1'b0, bus.word_count};
    range_bad = end_addr > (ADDR_W+2)'(DEPTH);
    issue = state_q == READ && !bus.abort;
    // Returns landing after an abort belong to a discarded scan.
    fold = vld_q[RD_LAT-1] && (state_q == READ || state_q == DRAIN) && !bus.abort;
    issue_nxt = issue_cnt_q + 1'b1;
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = !bus.start ? IDLE : (range_bad || bus.word_count == '0) ? FIN : READ;
      READ:    state_d = bus.abort ? FIN : issue_nxt == cnt_q ? DRAIN : READ;
      DRAIN:   state_d = bus.abort || ret_cnt_q == cnt_q ? FIN : DRAIN;
      default: state_d = IDLE;
    endcase
    // Results are registered on the edge entering FIN so they are valid alongside done.
    fin_entry = state_d == FIN && state_q != FIN;
    fin_err = state_q == IDLE ? range_bad : bus.abort;
    fin_crc = state_q == IDLE ? CRC_INIT : crc_q;
    fin_exp = state_q == IDLE ? bus.expected_crc : exp_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      base_q <= '0;
      cnt_q <= '0;
      exp_q <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q <= '0;
      vld_q <= '0;
      crc_q <= CRC_INIT;
      crc_out_q <= '0;
      error_q <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q <= accept ? '0 : (vld_q << 1) | RD_LAT'(issue);
      issue_cnt_q <= accept ? '0 : issue ? issue_nxt : issue_cnt_q;
      ret_cnt_q <= accept ? '0 : fold ? ret_cnt_q + 1'b1 : ret_cnt_q;
      crc_q <= accept ? CRC_INIT : fold ? crc_nxt : crc_q;
      if (accept) begin
        base_q <= bus.base_addr;
        cnt_q <= bus.word_count;
        exp_q <= bus.expected_crc;
        error_q <= 1'b0;
        mismatch_q <= 1'b0;
      end
      if (fin_entry) begin
        crc_out_q <= fin_crc;
        error_q <= fin_err;
        mismatch_q <= !fin_err && fin_crc != fin_exp;
      end
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == FIN;
  assign bus.error = error_q;
  assign bus.mismatch = mismatch_q;
  assign bus.crc_out = crc_out_q;
  assign bus.mem_chipselect = issue;
  assign bus.mem_address = issue ? base_q + issue_cnt_q[ADDR_W-1:0] : '0;
  assign bus.mem_write = 1'b0;
  assign bus.mem_clken = 1'b1;
  assign bus.mem_byteenable = {(DATA_W/8){1'b1}};
  assign bus.mem_writedata = '0;
endmodule

// File: tb/tb_onchip_mem_crc_checker.sv
// tb_onchip_mem_crc_checker: scoreboard bench with a 1-cycle-latency RAM model driving the checker through its interface
module tb_onchip_mem_crc_checker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  onchip_mem_crc_checker_if #(.ADDR_W(18)) bus ();
  onchip_mem_crc_checker #(.ADDR_W(18), .DATA_W(32), .DEPTH(204800), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  logic [31:0] ram [0:204799];
  logic [31:0] q_q = '0;
  always @(posedge clk) if (bus.mem_chipselect) q_q <= ram[bus.mem_address];
  assign bus.mem_readdata = q_q;
  typedef struct {logic [31:0] crc; logic err; logic mis;} res_t;
  res_t sb[$];
  logic [17:0] addr_q[$];
  logic [17:0] mon_a;
  int errors = 0, checks = 0, cs_total = 0, cs_rises = 0;
  logic cs_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset && bus.mem_chipselect) begin
      cs_total++;
      if (!cs_prev) cs_rises++;
      checks++;
      if (addr_q.size() == 0) begin
        errors++;
        $display("FAIL read_addr: got read at %0d, required no read", bus.mem_address);
      end else begin
        mon_a = addr_q.pop_front();
        if (bus.mem_address !== mon_a) begin
          errors++;
          $display("FAIL read_addr: got %0d, required %0d", bus.mem_address, mon_a);
        end
      end
    end
    cs_prev = !reset && bus.mem_chipselect;
  end
  function automatic logic [31:0] model_step(logic [31:0] c, logic [31:0] d);
    logic [63:0] v;
    v = {c ^ d, 32'h0};
    for (int i = 63; i >= 32; i--) if (v[i]) v ^= {31'b0, 1'b1, 32'h04C11DB7} << (i - 32);
    return v[31:0];
  endfunction
  function automatic logic [31:0] model_crc(int b, int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) c = model_step(c, ram[b+i]);
    return c;
  endfunction
  task automatic plan(input int b, input int issued, input int folded, input logic [31:0] e, input logic err);
    res_t r;
    r.crc = model_crc(b, folded);
    r.err = err;
    r.mis = !err && (r.crc != e);
    for (int i = 0; i < issued; i++) addr_q.push_back(18'(b + i));
    sb.push_back(r);
  endtask
  task automatic start_scan(input logic [17:0] b, input logic [18:0] n, input logic [31:0] e);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = b; bus.word_count = n; bus.expected_crc = e;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask
  task automatic wait_done(input int limit, output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (bus.done !== 1'b1 && lat < limit);
    if (bus.done !== 1'b1) lat = -1;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.error, bus.mismatch, bus.mem_chipselect} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 00000", {bus.busy, bus.done, bus.error, bus.mismatch, bus.mem_chipselect});
    end
    checks++;
    if ({bus.crc_out, bus.mem_address} !== 50'h0) begin
      errors++;
      $display("FAIL reset_data: got crc %h addr %0d, required 0 0", bus.crc_out, bus.mem_address);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask
  task automatic test_single;
    res_t r;
    int lat;
    ram[0] = 32'hFFFFFFFF;
    plan(0, 1, 1, 32'h0, 1'b0);
    start_scan(0, 1, 32'h0);
    wait_done(20, lat);
    r = sb.pop_front();
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL single_latency: got %0d, required 4", lat); end
    checks++;
    if ({bus.crc_out, bus.error, bus.mismatch} !== {r.crc, r.err, r.mis}) begin
      errors++;
      $display("FAIL single_result: got %h/%b/%b, required %h/%b/%b", bus.crc_out, bus.error, bus.mismatch, r.crc, r.err, r.mis);
    end
    checks++;
    if (bus.crc_out !== 32'h00000000) begin errors++; $display("FAIL single_crc_literal: got %h, required 00000000", bus.crc_out); end
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_at_done: got %b, required 1", bus.busy); end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL after_done: got busy/done %b, required 00", {bus.busy, bus.done}); end
    ram[5] = 32'hFFFFFFFE;
    plan(5, 1, 1, 32'h0, 1'b0);
    start_scan(5, 1, 32'h0);
    wait_done(20, lat);
    r = sb.pop_front();
    checks++;
    if ({bus.crc_out, bus.error, bus.mismatch} !== {r.crc, r.err, r.mis}) begin
      errors++;
      $display("FAIL poly_result: got %h/%b/%b, required %h/%b/%b", bus.crc_out, bus.error, bus.mismatch, r.crc, r.err, r.mis);
    end
    checks++;
    if ({bus.crc_out, bus.mismatch} !== {32'h04C11DB7, 1'b1}) begin
      errors++;
      $display("FAIL poly_literal: got %h/%b, required 04c11db7/1", bus.crc_out, bus.mismatch);
    end
  endtask
  task automatic test_random;
    res_t r;
    int lat, cs0, r0;
    logic [31:0] c;
    for (int i = 0; i < 1024; i++) ram[1000+i] = $urandom;
    c = model_crc(1000, 1024);
    plan(1000, 1024, 1024, c, 1'b0);
    cs0 = cs_total; r0 = cs_rises;
    start_scan(1000, 1024, c);
    wait_done(1100, lat);
    r = sb.pop_front();
    checks++;
    if (lat !== 1027) begin errors++; $display("FAIL random_latency: got %0d, required 1027", lat); end
    checks++;
    if ({bus.crc_out, bus.error, bus.mismatch} !== {r.crc, r.err, r.mis}) begin
      errors++;
      $display("FAIL random_result: got %h/%b/%b, required %h/%b/%b", bus.crc_out, bus.error, bus.mismatch, r.crc, r.err, r.mis);
    end
    checks++;
    if (cs_total - cs0 !== 1024 || cs_rises - r0 !== 1) begin
      errors++;
      $display("FAIL random_cs: got %0d reads in %0d bursts, required 1024 in 1", cs_total - cs0, cs_rises - r0);
    end
    checks++;
    if (addr_q.size() !== 0) begin errors++; $display("FAIL random_reads_left: got %0d unissued, required 0", addr_q.size()); end
  endtask
  task automatic test_range;
    res_t r;
    int lat, cs0;
    logic [31:0] c;
    plan(204700, 0, 0, 32'h0, 1'b1);
    cs0 = cs_total;
    start_scan(204700, 101, 32'h0);
    wait_done(5, lat);
    r = sb.pop_front();
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL range_bad_latency: got %0d, required 1", lat); end
    checks++;
    if ({bus.crc_out, bus.error, bus.mismatch} !== {r.crc, r.err, r.mis}) begin
      errors++;
      $display("FAIL range_bad_result: got %h/%b/%b, required %h/%b/%b", bus.crc_out, bus.error, bus.mismatch, r.crc, r.err, r.mis);
    end
    checks++;
    if (cs_total !== cs0) begin errors++; $display("FAIL range_bad_reads: got %0d, required 0", cs_total - cs0); end
    for (int i = 204700; i < 204800; i++) ram[i] = $urandom;
    c = model_crc(204700, 100);
    plan(204700, 100, 100, c, 1'b0);
    start_scan(204700, 100, c);
    wait_done(200, lat);
    r = sb.pop_front();
    checks++;
    if (lat !== 103) begin errors++; $display("FAIL range_edge_latency: got %0d, required 103", lat); end
    checks++;
    if ({bus.crc_out, bus.error, bus.mismatch} !== {r.crc, r.err, r.mis}) begin
      errors++;
      $display("FAIL range_edge_result: got %h/%b/%b, required %h/%b/%b", bus.crc_out, bus.error, bus.mismatch, r.crc, r.err, r.mis);
    end
    checks++;
    if (addr_q.size() !== 0) begin errors++; $display("FAIL range_edge_reads_left: got %0d, required 0", addr_q.size()); end
  endtask
  task automatic test_zero_and_ignore;
    res_t r;
    int lat, cs0;
    logic [31:0] c;
    plan(77, 0, 0, 32'h0, 1'b0);
    cs0 = cs_total;
    start_scan(77, 0, 32'h0);
    wait_done(5, lat);
    r = sb.pop_front();
    checks++;
    if (lat !== 1 || cs_total !== cs0) begin
      errors++;
      $display("FAIL zero_timing: got latency %0d reads %0d, required 1 and 0", lat, cs_total - cs0);
    end
    checks++;
    if ({bus.crc_out, bus.error, bus.mismatch} !== {r.crc, r.err, r.mis} || bus.crc_out !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL zero_result: got %h/%b/%b, required %h/%b/%b", bus.crc_out, bus.error, bus.mismatch, r.crc, r.err, r.mis);
    end
    for (int i = 3000; i < 3050; i++) ram[i] = $urandom;
    c = model_crc(3000, 50);
    plan(3000, 50, 50, c, 1'b0);
    cs0 = cs_total;
    start_scan(3000, 50, c);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = 0; bus.word_count = 5; bus.expected_crc = 32'h123;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(100, lat);
    r = sb.pop_front();
    checks++;
    if (lat !== 51) begin errors++; $display("FAIL ignore_latency: got %0d, required 51", lat); end
    checks++;
    if ({bus.crc_out, bus.error, bus.mismatch} !== {r.crc, r.err, r.mis} || cs_total - cs0 !== 50) begin
      errors++;
      $display("FAIL ignore_result: got %h/%b/%b reads %0d, required %h/%b/%b reads 50", bus.crc_out, bus.error, bus.mismatch, cs_total - cs0, r.crc, r.err, r.mis);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart: got busy %b, required 0", bus.busy); end
  endtask
  task automatic test_abort;
    res_t r;
    int cs0;
    for (int i = 5000; i < 5500; i++) ram[i] = $urandom;
    plan(5000, 10, 9, 32'h0, 1'b1);
    cs0 = cs_total;
    start_scan(5000, 500, 32'h0);
    repeat (10) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    r = sb.pop_front();
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL abort_done: got %b, required 1", bus.done); end
    checks++;
    if ({bus.crc_out, bus.error, bus.mismatch} !== {r.crc, r.err, r.mis}) begin
      errors++;
      $display("FAIL abort_result: got %h/%b/%b, required %h/%b/%b", bus.crc_out, bus.error, bus.mismatch, r.crc, r.err, r.mis);
    end
    checks++;
    if (cs_total - cs0 !== 10 || addr_q.size() !== 0) begin
      errors++;
      $display("FAIL abort_reads: got %0d issued %0d left, required 10 and 0", cs_total - cs0, addr_q.size());
    end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.error} !== 3'b001) begin
      errors++;
      $display("FAIL abort_after: got busy/done/error %b, required 001", {bus.busy, bus.done, bus.error});
    end
  endtask
  task automatic test_reset_mid;
    res_t r;
    int lat;
    logic [31:0] c;
    for (int i = 0; i < 200; i++) addr_q.push_back(18'(100 + i));
    start_scan(100, 200, 32'h0);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.error, bus.mismatch, bus.mem_chipselect, bus.crc_out, bus.mem_address} !== 55'h0) begin
      errors++;
      $display("FAIL reset_mid: got %b/%b/%b/%b/%b crc %h addr %0d, required all 0", bus.busy, bus.done, bus.error, bus.mismatch, bus.mem_chipselect, bus.crc_out, bus.mem_address);
    end
    addr_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 10; i < 18; i++) ram[i] = $urandom;
    c = model_crc(10, 8);
    plan(10, 8, 8, c, 1'b0);
    start_scan(10, 8, c);
    wait_done(30, lat);
    r = sb.pop_front();
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL fresh_latency: got %0d, required 11", lat); end
    checks++;
    if ({bus.crc_out, bus.error, bus.mismatch} !== {r.crc, r.err, r.mis}) begin
      errors++;
      $display("FAIL fresh_result: got %h/%b/%b, required %h/%b/%b", bus.crc_out, bus.error, bus.mismatch, r.crc, r.err, r.mis);
    end
  endtask
  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.base_addr = '0; bus.word_count = '0; bus.expected_crc = '0;
    test_reset();
    test_single();
    test_random();
    test_range();
    test_zero_and_ignore();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
